// File: rtl/ex_seg_reg_pkg.sv
// Shared definitions for the EX pipeline segment register: ALU op codes,
// operand-select encodings and the packed layout of the EX-stage registers.
package ex_seg_reg_pkg;

    // ALU operation codes shared with the decoder and the ALU
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLL  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_SLT  = 4'h8;
    localparam logic [3:0] ALU_SLTU = 4'h9;

    // Operand-1 select
    localparam logic       SRC1_RS1 = 1'b0;
    localparam logic       SRC1_PC  = 1'b1;

    // Operand-2 select; 2'b11 is unused and yields zero
    localparam logic [1:0] SRC2_RS2   = 2'b00;
    localparam logic [1:0] SRC2_SHAMT = 2'b01;
    localparam logic [1:0] SRC2_IMM   = 2'b10;

    // Everything the EX stage latches from ID
    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [3:0]  alu_ctrl;
        logic        alu_src1;
        logic [1:0]  alu_src2;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
    } ex_regs_t;

    // A bubble: nothing valid, no writeback, ADD op, all data cleared
    function automatic ex_regs_t ex_bubble();
        ex_regs_t b;
        b          = '0;
        b.alu_ctrl = ALU_ADD;
        return b;
    endfunction

endpackage

// File: rtl/ex_seg_reg_fwd_sel.sv
// fwd_sel: priority mux choosing the freshest value of one source register.
// MEM beats WB beats the register-file value; x0 is never forwarded.
module fwd_sel #(
    parameter int XLEN = 32
) (
    input  logic [4:0]      rs,
    input  logic [XLEN-1:0] rf_data,
    input  logic [4:0]      rd_m,
    input  logic            regwrite_m,
    input  logic [XLEN-1:0] alu_out_m,
    input  logic [4:0]      rd_w,
    input  logic            regwrite_w,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] data
);

    // Priority select of the forwarding source
    always_comb begin
        if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            data = alu_out_m;
        end else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            data = wb_data;
        end else begin
            data = rf_data;
        end
    end

endmodule

// File: rtl/ex_seg_reg.sv
// ex_seg_reg: ID->EX pipeline segment register with operand selection.
// Build option: define EX_FORWARD_EN to forward MEM/WB results into the
// operands; without it the registered register-file values are used and
// the hazard unit is expected to stall on every RAW hazard.
// Control: FlushE loads a bubble and wins over StallE; StallE holds.
module ex_seg_reg
    import ex_seg_reg_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic [XLEN-1:0] RegReadData1D,
    input  logic [XLEN-1:0] RegReadData2D,
    input  logic [XLEN-1:0] ImmD,
    input  logic [XLEN-1:0] PCD,
    input  logic            AluSrc1D,
    input  logic [1:0]      AluSrc2D,
    input  logic [3:0]      AluContrlD,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      RdD,
    input  logic            RegWriteD,
    input  logic [XLEN-1:0] AluOutM,
    input  logic [XLEN-1:0] RegWriteDataW,
    input  logic [4:0]      RdM,
    input  logic [4:0]      RdW,
    input  logic            RegWriteM,
    input  logic            RegWriteW,
    output logic [XLEN-1:0] Operand1E,
    output logic [XLEN-1:0] Operand2E,
    output logic [3:0]      AluContrlE,
    output logic [XLEN-1:0] StoreDataE,
    output logic [4:0]      RdE,
    output logic            RegWriteE,
    output logic            ValidE
);

    ex_regs_t        ex_d;
    ex_regs_t        ex_q;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    // Gather the ID-stage fields into the next EX register image
    always_comb begin
        ex_d          = '0;
        ex_d.valid    = 1'b1;
        ex_d.regwrite = RegWriteD;
        ex_d.rd       = RdD;
        ex_d.rs1      = Rs1D;
        ex_d.rs2      = Rs2D;
        ex_d.alu_ctrl = AluContrlD;
        ex_d.alu_src1 = AluSrc1D;
        ex_d.alu_src2 = AluSrc2D;
        ex_d.rd1      = RegReadData1D;
        ex_d.rd2      = RegReadData2D;
        ex_d.imm      = ImmD;
        ex_d.pc       = PCD;
    end

    // EX-stage registers: reset/flush load a bubble, stall holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= ex_bubble();
        end else if (FlushE) begin
            ex_q <= ex_bubble();
        end else if (!StallE) begin
            ex_q <= ex_d;
        end
    end

`ifdef EX_FORWARD_EN
    fwd_sel #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs         (ex_q.rs1),
        .rf_data    (ex_q.rd1),
        .rd_m       (RdM),
        .regwrite_m (RegWriteM),
        .alu_out_m  (AluOutM),
        .rd_w       (RdW),
        .regwrite_w (RegWriteW),
        .wb_data    (RegWriteDataW),
        .data       (rs1_val)
    );

    fwd_sel #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs         (ex_q.rs2),
        .rf_data    (ex_q.rd2),
        .rd_m       (RdM),
        .regwrite_m (RegWriteM),
        .alu_out_m  (AluOutM),
        .rd_w       (RdW),
        .regwrite_w (RegWriteW),
        .wb_data    (RegWriteDataW),
        .data       (rs2_val)
    );
`else
    // Sources disabled: the muxes reduce to the registered file values
    fwd_sel #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs         (ex_q.rs1),
        .rf_data    (ex_q.rd1),
        .rd_m       (5'd0),
        .regwrite_m (1'b0),
        .alu_out_m  ('0),
        .rd_w       (5'd0),
        .regwrite_w (1'b0),
        .wb_data    ('0),
        .data       (rs1_val)
    );

    fwd_sel #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs         (ex_q.rs2),
        .rf_data    (ex_q.rd2),
        .rd_m       (5'd0),
        .regwrite_m (1'b0),
        .alu_out_m  ('0),
        .rd_w       (5'd0),
        .regwrite_w (1'b0),
        .wb_data    ('0),
        .data       (rs2_val)
    );

    // Forwarding ports are intentionally ignored in this build
    logic unused_fwd;
    assign unused_fwd = ^{AluOutM, RegWriteDataW, RdM, RdW, RegWriteM, RegWriteW};
`endif

    // ALU operand selection from the (possibly forwarded) register values
    always_comb begin
        Operand1E = (ex_q.alu_src1 == SRC1_PC) ? ex_q.pc : rs1_val;
        case (ex_q.alu_src2)
            SRC2_RS2:   Operand2E = rs2_val;
            SRC2_SHAMT: Operand2E = {{(XLEN-5){1'b0}}, rs2_val[4:0]};
            SRC2_IMM:   Operand2E = ex_q.imm;
            default:    Operand2E = '0;
        endcase
    end

    // Remaining registered outputs; store data ignores the operand-2 select
    always_comb begin
        StoreDataE = rs2_val;
        AluContrlE = ex_q.alu_ctrl;
        RdE        = ex_q.rd;
        RegWriteE  = ex_q.regwrite;
        ValidE     = ex_q.valid;
    end

endmodule

// File: tb/tb_ex_seg_reg.sv
// Directed bench for ex_seg_reg: a table of {inputs, expected outputs}
// records applied one per clock, plus hand-written stall and reset sequences.
// Expectations for forwarding cases depend on EX_FORWARD_EN.
module tb_ex_seg_reg;
    import ex_seg_reg_pkg::*;

`ifdef EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        StallE, FlushE;
    logic [31:0] RegReadData1D, RegReadData2D, ImmD, PCD;
    logic        AluSrc1D;
    logic [1:0]  AluSrc2D;
    logic [3:0]  AluContrlD;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic        RegWriteD;
    logic [31:0] AluOutM, RegWriteDataW;
    logic [4:0]  RdM, RdW;
    logic        RegWriteM, RegWriteW;
    logic [31:0] Operand1E, Operand2E, StoreDataE;
    logic [3:0]  AluContrlE;
    logic [4:0]  RdE;
    logic        RegWriteE, ValidE;

    ex_seg_reg #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE),
        .RegReadData1D(RegReadData1D), .RegReadData2D(RegReadData2D),
        .ImmD(ImmD), .PCD(PCD), .AluSrc1D(AluSrc1D), .AluSrc2D(AluSrc2D),
        .AluContrlD(AluContrlD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteD(RegWriteD), .AluOutM(AluOutM), .RegWriteDataW(RegWriteDataW),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .Operand1E(Operand1E), .Operand2E(Operand2E), .AluContrlE(AluContrlE),
        .StoreDataE(StoreDataE), .RdE(RdE), .RegWriteE(RegWriteE), .ValidE(ValidE)
    );

    typedef struct {
        logic        stall, flush;
        logic [31:0] rd1, rd2, imm, pc;
        logic        src1;
        logic [1:0]  src2;
        logic [3:0]  alu;
        logic [4:0]  rs1, rs2, rd;
        logic        rw;
        logic [31:0] aluoutm, wbdata;
        logic [4:0]  rdm, rdw;
        logic        rwm, rww;
        logic [31:0] e_op1, e_op2, e_store;
        logic [3:0]  e_alu;
        logic [4:0]  e_rd;
        logic        e_rw, e_valid;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];
    int   errors = 0;
    int   checks = 0;

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, " ValidE"},     {31'd0, ValidE},     32'd0);
        chk({tag, " RegWriteE"},  {31'd0, RegWriteE},  32'd0);
        chk({tag, " RdE"},        {27'd0, RdE},        32'd0);
        chk({tag, " AluContrlE"}, {28'd0, AluContrlE}, {28'd0, ALU_ADD});
        chk({tag, " Operand1E"},  Operand1E,           32'd0);
        chk({tag, " Operand2E"},  Operand2E,           32'd0);
        chk({tag, " StoreDataE"}, StoreDataE,          32'd0);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input vec_t v);
        StallE = v.stall;  FlushE = v.flush;
        RegReadData1D = v.rd1; RegReadData2D = v.rd2; ImmD = v.imm; PCD = v.pc;
        AluSrc1D = v.src1; AluSrc2D = v.src2; AluContrlD = v.alu;
        Rs1D = v.rs1; Rs2D = v.rs2; RdD = v.rd; RegWriteD = v.rw;
        AluOutM = v.aluoutm; RegWriteDataW = v.wbdata;
        RdM = v.rdm; RdW = v.rdw; RegWriteM = v.rwm; RegWriteW = v.rww;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        vec_t z;
        z = '{default: '0};

        // 0: pass-through, imm operand
        v = z; v.rd1 = 32'h10; v.rd2 = 32'h22; v.imm = 32'hFFFF_FFFC; v.src2 = SRC2_IMM;
        v.alu = ALU_SUB; v.rs1 = 5'd1; v.rs2 = 5'd2; v.rd = 5'd3; v.rw = 1'b1;
        v.e_op1 = 32'h10; v.e_op2 = 32'hFFFF_FFFC; v.e_store = 32'h22;
        v.e_alu = ALU_SUB; v.e_rd = 5'd3; v.e_rw = 1'b1; v.e_valid = 1'b1;
        vecs[0] = v;
        // 1: PC operand, rs2 operand
        v = z; v.rd1 = 32'h99; v.rd2 = 32'h55; v.pc = 32'h1000; v.src1 = SRC1_PC;
        v.src2 = SRC2_RS2; v.alu = ALU_OR; v.rd = 5'd4;
        v.e_op1 = 32'h1000; v.e_op2 = 32'h55; v.e_store = 32'h55;
        v.e_alu = ALU_OR; v.e_rd = 5'd4; v.e_rw = 1'b0; v.e_valid = 1'b1;
        vecs[1] = v;
        // 2: shift amount from rs2
        v = z; v.rd1 = 32'h1; v.rd2 = 32'hFFFF_FFE3; v.src2 = SRC2_SHAMT; v.alu = ALU_SLL;
        v.rd = 5'd6; v.rw = 1'b1;
        v.e_op1 = 32'h1; v.e_op2 = 32'h3; v.e_store = 32'hFFFF_FFE3;
        v.e_alu = ALU_SLL; v.e_rd = 5'd6; v.e_rw = 1'b1; v.e_valid = 1'b1;
        vecs[2] = v;
        // 3: select 11 gives zero; store still rs2
        v = z; v.rd1 = 32'hCAFE; v.rd2 = 32'hBEEF; v.imm = 32'h7; v.src2 = 2'b11;
        v.alu = ALU_XOR; v.rd = 5'd8; v.rw = 1'b1;
        v.e_op1 = 32'hCAFE; v.e_op2 = 32'h0; v.e_store = 32'hBEEF;
        v.e_alu = ALU_XOR; v.e_rd = 5'd8; v.e_rw = 1'b1; v.e_valid = 1'b1;
        vecs[3] = v;
        // 4: stall holds entry 3 while ID changes
        v = z; v.stall = 1'b1; v.rd1 = 32'h1111; v.rd2 = 32'h2222; v.src2 = SRC2_RS2;
        v.alu = ALU_AND; v.rd = 5'd9;
        v.e_op1 = 32'hCAFE; v.e_op2 = 32'h0; v.e_store = 32'hBEEF;
        v.e_alu = ALU_XOR; v.e_rd = 5'd8; v.e_rw = 1'b1; v.e_valid = 1'b1;
        vecs[4] = v;
        // 5: flush loads a bubble
        v = z; v.flush = 1'b1; v.rd1 = 32'h3333; v.rd2 = 32'h4444; v.pc = 32'h40;
        v.src1 = SRC1_PC; v.alu = ALU_SRA; v.rd = 5'd10; v.rw = 1'b1;
        v.e_alu = ALU_ADD; vecs[5] = v;
        // 6: normal load before the stall+flush case
        v = z; v.rd1 = 32'h5; v.rd2 = 32'h6; v.alu = ALU_SLT; v.rd = 5'd11; v.rw = 1'b1;
        v.e_op1 = 32'h5; v.e_op2 = 32'h6; v.e_store = 32'h6;
        v.e_alu = ALU_SLT; v.e_rd = 5'd11; v.e_rw = 1'b1; v.e_valid = 1'b1;
        vecs[6] = v;
        // 7: stall and flush together -> flush wins
        v = z; v.stall = 1'b1; v.flush = 1'b1; v.rd1 = 32'h77; v.rd = 5'd12; v.rw = 1'b1;
        v.alu = ALU_SUB; v.e_alu = ALU_ADD; vecs[7] = v;
        // 8: MEM and WB both match rs1 -> MEM
        v = z; v.rd1 = 32'h77; v.rs1 = 5'd5; v.src2 = SRC2_IMM; v.imm = 32'h0; v.rd = 5'd13;
        v.aluoutm = 32'hA; v.wbdata = 32'hB; v.rdm = 5'd5; v.rdw = 5'd5; v.rwm = 1'b1; v.rww = 1'b1;
        v.e_op1 = FWD ? 32'hA : 32'h77; v.e_op2 = 32'h0; v.e_store = 32'h0;
        v.e_alu = ALU_ADD; v.e_rd = 5'd13; v.e_valid = 1'b1;
        vecs[8] = v;
        // 9: RegWriteM dropped -> WB
        v.rwm = 1'b0; v.e_op1 = FWD ? 32'hB : 32'h77; vecs[9] = v;
        // 10: x0 never forwarded
        v = z; v.rs2 = 5'd0; v.rd2 = 32'h0; v.src2 = SRC2_RS2; v.rd = 5'd14;
        v.aluoutm = 32'h1234; v.rdm = 5'd0; v.rwm = 1'b1;
        v.wbdata = 32'h5678; v.rdw = 5'd0; v.rww = 1'b1;
        v.e_op2 = 32'h0; v.e_store = 32'h0; v.e_alu = ALU_ADD; v.e_rd = 5'd14; v.e_valid = 1'b1;
        vecs[10] = v;
        // 11: forwarded shift amount
        v = z; v.rs2 = 5'd7; v.rd2 = 32'h10; v.src2 = SRC2_SHAMT; v.alu = ALU_SRL; v.rd = 5'd15;
        v.aluoutm = 32'hFFFF_FFE3; v.rdm = 5'd7; v.rwm = 1'b1;
        v.e_op2 = FWD ? 32'h3 : 32'h10; v.e_store = FWD ? 32'hFFFF_FFE3 : 32'h10;
        v.e_alu = ALU_SRL; v.e_rd = 5'd15; v.e_valid = 1'b1;
        vecs[11] = v;

        // reset state, checked with the clock running
        rst_n = 1'b0;
        drive(vecs[0]);
        #12;
        chk_bubble("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // table-driven vectors
        for (int i = 0; i < NV; i++) begin
            string tag;
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            tag = $sformatf("vec%0d", i);
            chk({tag, " Operand1E"},  Operand1E,  vecs[i].e_op1);
            chk({tag, " Operand2E"},  Operand2E,  vecs[i].e_op2);
            chk({tag, " StoreDataE"}, StoreDataE, vecs[i].e_store);
            chk({tag, " AluContrlE"}, {28'd0, AluContrlE}, {28'd0, vecs[i].e_alu});
            chk({tag, " RdE"},        {27'd0, RdE},        {27'd0, vecs[i].e_rd});
            chk({tag, " RegWriteE"},  {31'd0, RegWriteE},  {31'd0, vecs[i].e_rw});
            chk({tag, " ValidE"},     {31'd0, ValidE},     {31'd0, vecs[i].e_valid});
        end

        // three-cycle stall holds a loaded instruction
        @(negedge clk);
        v = z; v.rd1 = 32'hAAAA; v.imm = 32'h5; v.src2 = SRC2_IMM; v.alu = ALU_SUB;
        v.rd = 5'd9; v.rw = 1'b1;
        drive(v);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            v.stall = 1'b1; v.rd1 = 32'h100 + c; v.imm = 32'h200 + c; v.rd = 5'd20 + c[4:0];
            drive(v);
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d Operand1E", c), Operand1E, 32'hAAAA);
            chk($sformatf("stall%0d Operand2E", c), Operand2E, 32'h5);
            chk($sformatf("stall%0d RdE", c), {27'd0, RdE}, 32'd9);
            chk($sformatf("stall%0d ValidE", c), {31'd0, ValidE}, 32'd1);
        end

        // asynchronous reset during a stall discards the held instruction
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_bubble("async_reset");
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 chk_bubble("post_reset_stall");

        // resume on the first edge after reset release
        @(negedge clk);
        v = z; v.rd1 = 32'h10; v.imm = 32'hFFFF_FFFC; v.src2 = SRC2_IMM; v.rd = 5'd2; v.rw = 1'b1;
        drive(v);
        @(posedge clk);
        #1;
        chk("resume Operand1E", Operand1E, 32'h10);
        chk("resume Operand2E", Operand2E, 32'hFFFF_FFFC);
        chk("resume ValidE", {31'd0, ValidE}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_seg_reg.md
EX_SEG_REG -- requirements
Module: ex_seg_reg

Interface
REQ-001 Parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 clk  in  1  pipeline clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 StallE  in  1  hold all EX-stage registers.
REQ-005 FlushE  in  1  load a bubble into the EX stage.
REQ-006 RegReadData1D, RegReadData2D  in  32 each  register file read data from ID.
REQ-007 ImmD  in  32  sign-extended immediate; PCD  in  32  instruction PC.
REQ-008 AluSrc1D  in  1  operand-1 select: 0 = rs1, 1 = PC.
REQ-009 AluSrc2D  in  2  operand-2 select: 00 = rs2, 01 = rs2[4:0] zero-extended, 10 = imm.
REQ-010 AluContrlD  in  4  ALU operation code from the shared header.
REQ-011 Rs1D, Rs2D, RdD  in  5 each  register indices; RegWriteD  in  1  writeback enable.
REQ-012 AluOutM, RegWriteDataW  in  32 each  forwarding sources from MEM and WB.
REQ-013 RdM, RdW  in  5 each; RegWriteM, RegWriteW  in  1 each  forwarding qualifiers.
REQ-014 Operand1E, Operand2E  out  32 each  ALU operands; AluContrlE  out  4  ALU operation code.
REQ-015 StoreDataE  out  32  forwarded rs2 value for stores; RdE  out  5; RegWriteE  out  1; ValidE  out  1.

Function
REQ-016 With StallE=0 and FlushE=0, ID inputs sampled at edge N SHALL appear on the EX outputs after edge N, giving one-cycle latency.
REQ-017 With StallE=1 and FlushE=0, all registers SHALL hold their values.
REQ-018 FlushE=1 SHALL load a bubble: ValidE=0, RegWriteE=0, RdE=0, AluContrlE=`ADD, and all data registers 0.
REQ-019 If FlushE and StallE are both 1, the flush SHALL win.
REQ-020 Forwarding SHALL be combinational on the registered Rs1E/Rs2E and SHALL add zero cycles of latency.
REQ-021 The MEM source SHALL be selected when RegWriteM=1, RdM!=0 and RdM==Rs1E (or Rs2E).
REQ-022 Otherwise the WB source SHALL be selected when RegWriteW=1, RdW!=0 and RdW==Rs1E (or Rs2E).
REQ-023 Otherwise the registered register-file value SHALL be used.
REQ-024 When both MEM and WB match, MEM SHALL take priority.
REQ-025 Register index 0 SHALL never be forwarded.
REQ-026 Operand1E SHALL be PCE when AluSrc1E=1 and the forwarded rs1 value otherwise.
REQ-027 Operand2E SHALL be selected per AluSrc2E from the forwarded rs2 value, its low 5 bits zero-extended, or ImmE.
REQ-028 AluSrc2E=11 SHALL output 0.
REQ-029 StoreDataE SHALL always be the forwarded rs2 value, independent of AluSrc2E.

Reset
REQ-030 rst_n=0 SHALL asynchronously force the bubble state of REQ-018, with PCE=0 and Rs1E=Rs2E=0.
REQ-031 Deassertion of rst_n SHALL be synchronised upstream; the block SHALL resume on the first clk edge after rst_n=1.
REQ-032 Reset asserted mid-stall SHALL discard the held instruction.

Configuration
REQ-033 Macro EX_FORWARD_EN: when defined, REQ-020 to REQ-025 SHALL apply.
REQ-034 When EX_FORWARD_EN is undefined, the registered register-file values SHALL be used directly, the MEM/WB forwarding inputs SHALL be unused, and the hazard unit SHALL stall on all RAW hazards.

Structure
REQ-035 The ALU op codes (`ADD etc.) and the operand-select encodings SHALL live in the shared Parameters.v header.
REQ-036 The forwarding priority mux SHALL be one sub-module, fwd_sel, instantiated twice (rs1, rs2).

Verification
REQ-037 Reset: rst_n=0 mid-stream -> ValidE=0, RegWriteE=0, AluContrlE=`ADD, Operand1E=Operand2E=0 immediately, without a clk edge.
REQ-038 Pass-through: RegReadData1D=0x10, ImmD=0xFFFFFFFC, AluSrc2D=10 -> after one edge Operand1E=0x10, Operand2E=0xFFFFFFFC.
REQ-039 Stall/flush: StallE=1 for 3 cycles -> outputs unchanged; StallE=FlushE=1 -> bubble on the next edge.
REQ-040 Forward priority: Rs1E=5, RdM=RdW=5, both RegWrite=1, AluOutM=0xA, RegWriteDataW=0xB -> Operand1E=0xA; drop RegWriteM -> 0xB.
REQ-041 x0: Rs2E=0, RdM=0, RegWriteM=1, AluOutM=0x1234, RegReadData2 registered 0 -> StoreDataE=0.
REQ-042 Shift amount: forwarded rs2=0xFFFFFFE3, AluSrc2E=01 -> Operand2E=0x00000003.
